// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - in-order memory request queue and response router
// Optional RESP_REGISTER_EN registers the response strobes and load_data.
module mem_responder #(
   parameter int MAIN_ADDR_WIDTH = 16,
   parameter int WORD_WIDTH      = 32,
   parameter int QUEUE_DEPTH     = 4,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       write_out,
   input  logic [MAIN_ADDR_WIDTH-1:0] write_address,
   input  logic [WORD_WIDTH-1:0]      write_value,
   input  logic [MAIN_ADDR_WIDTH-1:0] read_address,
   input  logic                       reload,
   input  logic                       conveyor_memload,
   input  logic                       dstack_memload,
   output logic                       busy,
   output logic                       overflow,
   output logic                       fetch_valid,
   output logic                       conveyor_valid,
   output logic                       dstack_valid,
   output logic [WORD_WIDTH-1:0]      load_data,
   output logic                       mem_req_valid,
   input  logic                       mem_req_ready,
   output logic                       mem_req_write,
   output logic [MAIN_ADDR_WIDTH-1:0] mem_req_addr,
   output logic [WORD_WIDTH-1:0]      mem_req_wdata,
   input  logic                       mem_resp_valid,
   input  logic [WORD_WIDTH-1:0]      mem_resp_data
);

   localparam int QAW = $clog2(QUEUE_DEPTH);
   localparam int QCW = QAW + 1;
   localparam int TAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int TCW = $clog2(MAX_OUTSTANDING) + 1;

   localparam logic [1:0] DEST_FETCH    = 2'd0;
   localparam logic [1:0] DEST_CONVEYOR = 2'd1;
   localparam logic [1:0] DEST_DSTACK   = 2'd2;

   logic                       q_write [QUEUE_DEPTH];
   logic [MAIN_ADDR_WIDTH-1:0] q_addr  [QUEUE_DEPTH];
   logic [WORD_WIDTH-1:0]      q_wdata [QUEUE_DEPTH];
   logic [1:0]                 q_dest  [QUEUE_DEPTH];
   logic                       q_stale [QUEUE_DEPTH];
   logic [QAW-1:0]             q_rd, q_wr, r_slot;
   logic [QCW-1:0]             q_count;

   logic [1:0]                 t_dest  [MAX_OUTSTANDING];
   logic                       t_stale [MAX_OUTSTANDING];
   logic [TAW-1:0]             t_rd, t_wr;
   logic [TCW-1:0]             t_count;

   logic read_req, any_req, accept, push_w, push_r, flush;
   logic q_empty, head_is_read, t_full, pop, issue_read, head_stale;
   logic resp_fire, deliver_fetch, deliver_conveyor, deliver_dstack, deliver_any;
   logic [1:0] read_dest;

   function automatic logic [TAW-1:0] t_next(input logic [TAW-1:0] p);
      return (p == TAW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      read_req   = reload | conveyor_memload | dstack_memload;
      any_req    = write_out | read_req;
      busy       = q_count > QCW'(QUEUE_DEPTH - 2);
      accept     = !reset && !busy;
      push_w     = accept && write_out;
      push_r     = accept && read_req;
      flush      = accept && reload;
      r_slot     = q_wr + QAW'(push_w);
      read_dest  = reload ? DEST_FETCH : (conveyor_memload ? DEST_CONVEYOR : DEST_DSTACK);

      q_empty       = (q_count == '0);
      head_is_read  = !q_write[q_rd];
      t_full        = (t_count == TCW'(MAX_OUTSTANDING));
      mem_req_valid = !reset && !q_empty && !(head_is_read && t_full);
      mem_req_write = !q_empty && q_write[q_rd];
      mem_req_addr  = q_empty ? '0 : q_addr[q_rd];
      mem_req_wdata = q_empty ? '0 : q_wdata[q_rd];
      pop           = mem_req_valid && mem_req_ready;
      issue_read    = pop && head_is_read;
      // A fetch leaving the queue on the same edge as a reload is already stale.
      head_stale    = q_stale[q_rd] || (flush && q_dest[q_rd] == DEST_FETCH);

      resp_fire        = !reset && mem_resp_valid && (t_count != '0);
      deliver_fetch    = resp_fire && !t_stale[t_rd] && t_dest[t_rd] == DEST_FETCH;
      deliver_conveyor = resp_fire && !t_stale[t_rd] && t_dest[t_rd] == DEST_CONVEYOR;
      deliver_dstack   = resp_fire && !t_stale[t_rd] && t_dest[t_rd] == DEST_DSTACK;
      deliver_any      = deliver_fetch || deliver_conveyor || deliver_dstack;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q_rd    <= '0;
         q_wr    <= '0;
         q_count <= '0;
      end else begin
         if (flush) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
               if (q_dest[i] == DEST_FETCH) q_stale[i] <= 1'b1;
            end
         end
         if (push_w) begin
            q_write[q_wr] <= 1'b1;
            q_addr[q_wr]  <= write_address;
            q_wdata[q_wr] <= write_value;
            q_dest[q_wr]  <= DEST_DSTACK;
            q_stale[q_wr] <= 1'b0;
         end
         if (push_r) begin
            q_write[r_slot] <= 1'b0;
            q_addr[r_slot]  <= read_address;
            q_wdata[r_slot] <= '0;
            q_dest[r_slot]  <= read_dest;
            q_stale[r_slot] <= 1'b0;
         end
         if (pop) q_rd <= q_rd + 1'b1;
         q_wr    <= q_wr + QAW'(push_w) + QAW'(push_r);
         q_count <= q_count + QCW'(push_w) + QCW'(push_r) - QCW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         t_rd    <= '0;
         t_wr    <= '0;
         t_count <= '0;
      end else begin
         if (flush) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
               if (t_dest[i] == DEST_FETCH) t_stale[i] <= 1'b1;
            end
         end
         if (issue_read) begin
            t_dest[t_wr]  <= q_dest[q_rd];
            t_stale[t_wr] <= head_stale;
            t_wr          <= t_next(t_wr);
         end
         if (resp_fire) t_rd <= t_next(t_rd);
         t_count <= t_count + TCW'(issue_read) - TCW'(resp_fire);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) overflow <= 1'b0;
      else       overflow <= any_req && busy;
   end

`ifdef RESP_REGISTER_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_valid    <= 1'b0;
         conveyor_valid <= 1'b0;
         dstack_valid   <= 1'b0;
         load_data      <= '0;
      end else begin
         fetch_valid    <= deliver_fetch;
         conveyor_valid <= deliver_conveyor;
         dstack_valid   <= deliver_dstack;
         load_data      <= deliver_any ? mem_resp_data : '0;
      end
   end
`else
   always_comb begin
      fetch_valid    = deliver_fetch;
      conveyor_valid = deliver_conveyor;
      dstack_valid   = deliver_dstack;
      load_data      = deliver_any ? mem_resp_data : '0;
   end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized and directed checks of mem_responder against a queue model
module tb_mem_responder;
   localparam int AW = 16;
   localparam int WW = 32;
   localparam int QD = 4;
   localparam int MO = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          write_out = 1'b0;
   logic [AW-1:0] write_address = '0;
   logic [WW-1:0] write_value = '0;
   logic [AW-1:0] read_address = '0;
   logic          reload = 1'b0, conveyor_memload = 1'b0, dstack_memload = 1'b0;
   logic          busy, overflow, fetch_valid, conveyor_valid, dstack_valid;
   logic [WW-1:0] load_data;
   logic          mem_req_valid, mem_req_write;
   logic          mem_req_ready = 1'b0;
   logic [AW-1:0] mem_req_addr;
   logic [WW-1:0] mem_req_wdata;
   logic          mem_resp_valid = 1'b0;
   logic [WW-1:0] mem_resp_data = '0;

   mem_responder #(.MAIN_ADDR_WIDTH(AW), .WORD_WIDTH(WW), .QUEUE_DEPTH(QD), .MAX_OUTSTANDING(MO)) dut (
      .clk(clk), .reset(reset), .write_out(write_out), .write_address(write_address),
      .write_value(write_value), .read_address(read_address), .reload(reload),
      .conveyor_memload(conveyor_memload), .dstack_memload(dstack_memload),
      .busy(busy), .overflow(overflow), .fetch_valid(fetch_valid),
      .conveyor_valid(conveyor_valid), .dstack_valid(dstack_valid), .load_data(load_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
      .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid),
      .mem_resp_data(mem_resp_data)
   );

   always #5 clk = ~clk;

   typedef struct {bit wr; logic [AW-1:0] addr; logic [WW-1:0] wd; int dest; bit stale;} ent_t;
   typedef struct {int dest; bit stale; logic [WW-1:0] data;} tag_t;

   int total = 0, bad = 0;

   // stimulus knobs
   logic          d_rst = 1'b1, d_wr = 1'b0, d_rl = 1'b0, d_cv = 1'b0, d_ds = 1'b0, d_rdy = 1'b1;
   logic [AW-1:0] d_wa = '0, d_ra = '0;
   logic [WW-1:0] d_wv = '0;
   bit            resp_hold = 0, spur_en = 0;
   int            resp_pct = 100;

   // RAM environment
   logic [WW-1:0] pend[$];
   logic [WW-1:0] eram [bit [AW-1:0]];

   // reference model
   ent_t          mq[$];
   tag_t          mt[$];
   logic [WW-1:0] mmem [bit [AW-1:0]];
   bit            m_ovf = 0;
   int            m_prev_dest = -1;
   logic [WW-1:0] m_prev_data = '0;

   // DUT outputs seen at the last negedge
   logic          o_valid, o_write, o_busy, o_ovf, o_fv, o_cv, o_dv;
   logic [AW-1:0] o_addr;
   logic [WW-1:0] o_wdata, o_ld;

   function automatic logic [WW-1:0] dflt(input logic [AW-1:0] a);
      return {16'hA5A5, a};
   endfunction
   function automatic logic [WW-1:0] eget(input logic [AW-1:0] a);
      return eram.exists(a) ? eram[a] : dflt(a);
   endfunction
   function automatic logic [WW-1:0] mget(input logic [AW-1:0] a);
      return mmem.exists(a) ? mmem[a] : dflt(a);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_idle();
      d_wr = 1'b0; d_rl = 1'b0; d_cv = 1'b0; d_ds = 1'b0;
   endtask

   // One clock: drive at posedge+1, check at negedge, advance env and model at posedge.
   task automatic cycle();
      logic          rv;
      logic [WW-1:0] rdat, now_data, sdat;
      bit            hv, e_valid, e_busy, req, acc;
      int            now_dest, sd;
      ent_t          h;
      reset = d_rst; write_out = d_wr; write_address = d_wa; write_value = d_wv;
      read_address = d_ra; reload = d_rl; conveyor_memload = d_cv; dstack_memload = d_ds;
      mem_req_ready = d_rdy;
      rv = 1'b0; rdat = '0;
      if (!resp_hold && pend.size() > 0 && $urandom_range(99) < resp_pct) begin
         rv = 1'b1; rdat = pend[0];
      end else if (spur_en && pend.size() == 0 && mt.size() == 0 && $urandom_range(9) == 0) begin
         rv = 1'b1; rdat = $urandom;
      end
      mem_resp_valid = rv; mem_resp_data = rdat;
      #1;
      hv      = mq.size() > 0;
      e_valid = !d_rst && hv && !(!mq[0].wr && mt.size() == MO);
      e_busy  = mq.size() > QD - 2;
      now_dest = -1; now_data = '0;
      if (!d_rst && rv && mt.size() > 0 && !mt[0].stale) begin
         now_dest = mt[0].dest; now_data = mt[0].data;
      end
`ifdef RESP_REGISTER_EN
      sd = m_prev_dest; sdat = m_prev_data;
`else
      sd = now_dest; sdat = now_data;
`endif
      @(negedge clk);
      o_valid = mem_req_valid; o_write = mem_req_write; o_addr = mem_req_addr;
      o_wdata = mem_req_wdata; o_busy = busy; o_ovf = overflow; o_fv = fetch_valid;
      o_cv = conveyor_valid; o_dv = dstack_valid; o_ld = load_data;
      chk("busy", o_busy, e_busy);
      chk("overflow", o_ovf, m_ovf);
      chk("mem_req_valid", o_valid, e_valid);
      chk("mem_req_write", o_write, hv ? mq[0].wr : 1'b0);
      chk("mem_req_addr", o_addr, hv ? mq[0].addr : '0);
      chk("mem_req_wdata", o_wdata, hv ? mq[0].wd : '0);
      chk("fetch_valid", o_fv, sd == 0);
      chk("conveyor_valid", o_cv, sd == 1);
      chk("dstack_valid", o_dv, sd == 2);
      chk("load_data", o_ld, (sd >= 0) ? sdat : '0);
      @(posedge clk);
      if (rv && pend.size() > 0) void'(pend.pop_front());
      if (o_valid && d_rdy) begin
         if (o_write) eram[o_addr] = o_wdata;
         else pend.push_back(eget(o_addr));
      end
      if (d_rst) begin
         mq.delete(); mt.delete(); m_ovf = 0; m_prev_dest = -1; m_prev_data = '0;
      end else begin
         m_prev_dest = now_dest; m_prev_data = now_data;
         req   = d_wr || d_rl || d_cv || d_ds;
         m_ovf = req && e_busy;
         acc   = req && !e_busy;
         if (rv && mt.size() > 0) void'(mt.pop_front());
         if (e_valid && d_rdy) begin
            h = mq.pop_front();
            if (h.wr) mmem[h.addr] = h.wd;
            else mt.push_back('{h.dest, h.stale, mget(h.addr)});
         end
         if (acc && d_rl) begin
            foreach (mt[i]) if (mt[i].dest == 0) mt[i].stale = 1;
            foreach (mq[i]) if (!mq[i].wr && mq[i].dest == 0) mq[i].stale = 1;
         end
         if (acc && d_wr) mq.push_back('{1'b1, d_wa, d_wv, 2, 1'b0});
         if (acc && (d_rl || d_cv || d_ds))
            mq.push_back('{1'b0, d_ra, '0, d_rl ? 0 : (d_cv ? 1 : 2), 1'b0});
      end
      #1;
   endtask

   initial begin
      int n, nf;
      bit seen;
      logic [WW-1:0] fdata;
      @(posedge clk); #1;
      d_rst = 1'b1; cycle(); cycle();
      d_rst = 1'b0; cycle();
      chk("reset busy", o_busy, 0);
      chk("reset req_valid", o_valid, 0);
      chk("reset overflow", o_ovf, 0);
      chk("reset strobes", {o_fv, o_cv, o_dv}, 0);

      // single write
      d_wr = 1'b1; d_wa = 16'h0010; d_wv = 32'hDEADBEEF; cycle();
      chk("t1 same cycle valid", o_valid, 0);
      set_idle(); cycle();
      chk("t1 valid", o_valid, 1); chk("t1 write", o_write, 1);
      chk("t1 addr", o_addr, 16'h0010); chk("t1 wdata", o_wdata, 32'hDEADBEEF);
      cycle();
      chk("t1 drained", o_valid, 0);

      // write then read in one cycle
      d_wr = 1'b1; d_ds = 1'b1; d_ra = 16'h0010; cycle();
      set_idle(); cycle();
      chk("t2 first is write", {o_valid, o_write}, 2'b11);
      cycle();
      chk("t2 second is read", {o_valid, o_write}, 2'b10);
      chk("t2 read addr", o_addr, 16'h0010);
      seen = 0;
      for (int i = 0; i < 8 && !seen; i++) begin
         cycle();
         if (o_fv || o_cv || o_dv) seen = 1;
      end
      chk("t2 resp seen", seen, 1);
      chk("t2 strobes", {o_fv, o_cv, o_dv}, 3'b001);
      chk("t2 data", o_ld, 32'hDEADBEEF);

      // fill while stalled, overflow, drain
      d_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         d_ds = 1'b1; d_ra = 16'h0020 + 16'(i); cycle();
         chk("t3 not busy yet", o_busy, 0);
      end
      d_ra = 16'h0030; cycle();
      chk("t3 busy", o_busy, 1);
      set_idle(); cycle();
      chk("t3 overflow pulse", o_ovf, 1);
      cycle();
      chk("t3 overflow once", o_ovf, 0);
      d_rdy = 1'b1; n = 0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (o_valid && !o_write) n++;
      end
      chk("t3 drained reads", n, 3);

      // reload flushes earlier fetches
      resp_hold = 1;
      d_rl = 1'b1; d_ra = 16'h0040; cycle();
      d_ra = 16'h0041; cycle();
      set_idle(); cycle(); cycle();
      d_rl = 1'b1; d_ra = 16'h0100; cycle();
      set_idle(); cycle(); cycle();
      resp_hold = 0; nf = 0; fdata = '0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (o_fv) begin nf++; fdata = o_ld; end
      end
      chk("t4 fetch count", nf, 1);
      chk("t4 fetch data", fdata, 32'hA5A50100);

      // outstanding limit
      resp_hold = 1;
      for (int i = 0; i < 5; i++) begin
         d_cv = 1'b1; d_ra = 16'h0050 + 16'(i); cycle();
      end
      set_idle();
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("t5 fifth held", o_valid, 0);
      end
      resp_hold = 0; seen = 0;
      for (int i = 0; i < 6 && !seen; i++) begin
         cycle();
         if (o_valid && o_addr == 16'h0054) seen = 1;
      end
      chk("t5 fifth issued", seen, 1);
      for (int i = 0; i < 8; i++) cycle();

      // reset with reads in flight
      resp_hold = 1;
      d_ds = 1'b1; d_ra = 16'h0060; cycle();
      d_ra = 16'h0061; cycle();
      set_idle(); cycle(); cycle();
      d_rst = 1'b1; cycle();
      d_rst = 1'b0; resp_hold = 0; n = 0;
      for (int i = 0; i < 6; i++) begin
         cycle();
         if (o_fv || o_cv || o_dv) n++;
      end
      chk("t6 stale strobes", n, 0);
      d_cv = 1'b1; d_ra = 16'h0070; cycle();
      set_idle(); seen = 0;
      for (int i = 0; i < 8 && !seen; i++) begin
         cycle();
         if (o_cv) seen = 1;
      end
      chk("t6 conveyor seen", seen, 1);
      chk("t6 conveyor data", o_ld, 32'hA5A50070);

      // randomized traffic
      spur_en = 1;
      for (int c = 0; c < 3000; c++) begin
         if (c % 200 == 0) resp_pct = ($urandom_range(2) == 0) ? 20 : (($urandom_range(1) == 0) ? 60 : 100);
         d_wr = ($urandom_range(3) == 0);
         d_wa = 16'($urandom_range(15));
         d_wv = $urandom;
         d_rl = ($urandom_range(9) == 0);
         d_cv = ($urandom_range(4) == 0);
         d_ds = ($urandom_range(3) == 0);
         d_ra = 16'($urandom_range(15));
         d_rdy = ($urandom_range(9) < 7);
         cycle();
      end
      set_idle(); d_rdy = 1'b1; resp_pct = 100; spur_en = 0;
      for (int i = 0; i < 30; i++) cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
